// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter onto a multiplexed address/data memory bus (ADDR, DATA, ACK, optional TURN).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed priority to requester 0.
module mem_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic       rd0,
    input  logic       rd1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    inout  wire  [7:0] uniBus,
    output logic       ale,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, ACK, TURN} state_t;

    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    logic       id_q, id_d;
    logic       rd_q, rd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] turn_q, turn_d;
    logic       grant;
    logic       drive_en;
    logic [7:0] bus_out;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Id of the requester served most recently; reset to 1 so requester 0 wins first.
    logic last_q, last_d;

    always_comb begin
        grant = (req0 && req1) ? ~last_q : ~req0;
    end
`else
    always_comb begin
        grant = ~req0;
    end
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        turn_d  = turn_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    id_d    = grant;
                    rd_d    = grant ? rd1 : rd0;
                    addr_d  = grant ? addr1 : addr0;
                    wdata_d = grant ? wdata1 : wdata0;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                if (rd_q) begin
                    rdata_d = uniBus;
                end
                state_d = ACK;
            end
            ACK: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_d = id_q;
`endif
                if (TURN_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = TURN;
                    turn_d  = TURN_LAST;
                end
            end
            TURN: begin
                if (turn_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            turn_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            turn_q  <= turn_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs decode purely from registered state, so reset clears them one edge later.
    always_comb begin
        ale      = (state_q == ADDR);
        mem_rd   = (state_q == DATA) && rd_q;
        mem_we   = (state_q == DATA) && !rd_q;
        ack0     = (state_q == ACK) && !id_q;
        ack1     = (state_q == ACK) && id_q;
        busy     = (state_q != IDLE);
        drive_en = ale || mem_we;
        bus_out  = ale ? addr_q : wdata_q;
    end

    assign uniBus = drive_en ? bus_out : 'z;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: TURN_CYCLES=0 and =1 instances share stimulus; a timeline model
// predicts every output each cycle, and directed scenarios pin latencies and data with literals.
module tb_mem_bus_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic       req0, req1, rd0, rd1;
    logic [7:0] addr0, addr1, wdata0, wdata1;

    logic       ack0_t0, ack1_t0, ale_t0, mrd_t0, mwe_t0, busy_t0;
    logic       ack0_t1, ack1_t1, ale_t1, mrd_t1, mwe_t1, busy_t1;
    logic [7:0] rdata_t0, rdata_t1;
    wire  [7:0] bus_t0, bus_t1;

    mem_bus_arbiter #(.TURN_CYCLES(0)) u_t0 (
        .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_t0), .ack1(ack1_t0), .rdata(rdata_t0), .uniBus(bus_t0),
        .ale(ale_t0), .mem_rd(mrd_t0), .mem_we(mwe_t0), .busy(busy_t0)
    );

    mem_bus_arbiter #(.TURN_CYCLES(1)) u_t1 (
        .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_t1), .ack1(ack1_t1), .rdata(rdata_t1), .uniBus(bus_t1),
        .ale(ale_t1), .mem_rd(mrd_t1), .mem_we(mwe_t1), .busy(busy_t1)
    );

    // Bus-side memory devices, one per instance; index d equals that instance's TURN_CYCLES.
    logic [7:0] dmem [2][256];
    logic [7:0] dlat [2];
    assign bus_t0 = mrd_t0 ? dmem[0][dlat[0]] : 'z;
    assign bus_t1 = mrd_t1 ? dmem[1][dlat[1]] : 'z;

    // st = {ale, mem_rd, mem_we, ack0, ack1, busy}
    logic [5:0] st [2];
    logic [7:0] rdv [2];
    logic [7:0] busv [2];
    logic       bz [2];
    always_comb begin
        st[0]   = {ale_t0, mrd_t0, mwe_t0, ack0_t0, ack1_t0, busy_t0};
        st[1]   = {ale_t1, mrd_t1, mwe_t1, ack0_t1, ack1_t1, busy_t1};
        rdv[0]  = rdata_t0;
        rdv[1]  = rdata_t1;
        busv[0] = bus_t0;
        busv[1] = bus_t1;
        bz[0]   = (bus_t0 === 8'hzz);
        bz[1]   = (bus_t1 === 8'hzz);
    end

    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (st[d][5]) dlat[d] <= busv[d];
            if (st[d][3]) dmem[d][dlat[d]] <= busv[d];
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int n = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, a, e, n);
    endtask

    // Timeline model: a transfer granted at edge t0 shows ADDR, DATA, ACK in the three cycles
    // after edges t0..t0+2, and the next grant can happen no earlier than edge t0+4+TURN.
    bit         mact [2];
    int         mt0 [2];
    logic       mid [2], mrdl [2];
    logic [7:0] madr [2], mwd [2], mrdata [2];
    logic [7:0] mm [2][256];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic       mrr [2];
`endif

    always @(posedge CLK) begin
        n++;
        for (int d = 0; d < 2; d++) begin
            if (!RST) begin
                mact[d]   = 1'b0;
                mrdata[d] = 8'h00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                mrr[d]    = 1'b1;
`endif
            end else begin
                if (mact[d] && n == mt0[d] + 2) begin
                    if (mrdl[d]) mrdata[d] = mm[d][madr[d]];
                    else mm[d][madr[d]] = mwd[d];
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (mact[d] && n == mt0[d] + 3) mrr[d] = mid[d];
`endif
                if (!mact[d] || n >= mt0[d] + 4 + d) begin
                    if (req0 || req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        mid[d] = (req0 && req1) ? !mrr[d] : !req0;
`else
                        mid[d] = !req0;
`endif
                        mrdl[d] = mid[d] ? rd1 : rd0;
                        madr[d] = mid[d] ? addr1 : addr0;
                        mwd[d]  = mid[d] ? wdata1 : wdata0;
                        mt0[d]  = n;
                        mact[d] = 1'b1;
                    end else begin
                        mact[d] = 1'b0;
                    end
                end
            end
        end
    end

    int         p;
    logic       ea, ed, eack, eb;
    logic [5:0] ex;
    logic [1:0] viol;
    always @(negedge CLK) begin
        if (n > 0) begin
            for (int d = 0; d < 2; d++) begin
                p    = n - mt0[d];
                ea   = mact[d] && p == 0;
                ed   = mact[d] && p == 1;
                eack = mact[d] && p == 2;
                eb   = mact[d] && p <= 2 + d;
                ex   = {ea, ed & mrdl[d], ed & ~mrdl[d], eack & ~mid[d], eack & mid[d], eb};
                chk($sformatf("ctl_t%0d", d), 32'(st[d]), 32'(ex));
                chk($sformatf("rdata_t%0d", d), 32'(rdv[d]), 32'(mrdata[d]));
                if (ea) chk($sformatf("bus_addr_t%0d", d), 32'(busv[d]), 32'(madr[d]));
                else if (ed && !mrdl[d]) chk($sformatf("bus_wdata_t%0d", d), 32'(busv[d]), 32'(mwd[d]));
                else if (!ed) chk($sformatf("bus_z_t%0d", d), 32'(bz[d]), 1);
                viol = {st[d][2] & st[d][1], 1'($countones(st[d][5:3]) > 1)};
                chk($sformatf("exclusive_t%0d", d), 32'(viol), 0);
            end
        end
    end

    task automatic wait_for(input int d, input int bitn, input int budget, output int cnt);
        cnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (st[d][bitn]) begin
                cnt = i;
                break;
            end
        end
        chk($sformatf("seen_t%0d_bit%0d", d, bitn), 32'(cnt != 0), 1);
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge CLK);
    endtask

    int c;
    int cnt_acks;
    int ids [4];
    int cyc [4];
    logic [7:0] rds [4];
    int eids [4];

    initial begin
        RST = 1'b0; req0 = 1'b0; req1 = 1'b0; rd0 = 1'b1; rd1 = 1'b1;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                dmem[d][i] = 8'(32'h10 + i);
                mm[d][i]   = 8'(32'h10 + i);
            end
        end
        for (int j = 0; j < 4; j++) begin
            ids[j] = -1; cyc[j] = 0; rds[j] = '0;
        end

        repeat (3) @(negedge CLK);
        chk("rst_ctl", 32'(st[1]), 0);
        chk("rst_rdata", 32'(rdv[1]), 0);
        chk("rst_busz", 32'(bz[1]), 1);
        RST = 1'b1;
        idle(2);

        // Read of preset location 2
        req0 = 1'b1; rd0 = 1'b1; addr0 = 8'h02; wdata0 = 8'h77;
        @(negedge CLK);
        chk("rd_ale", 32'(st[1][5]), 1);
        chk("rd_addr", 32'(busv[1]), 'h02);
        wait_for(1, 2, 8, c);
        chk("rd_ack_lat", c, 2);
        chk("rd_data", 32'(rdv[1]), 'h12);
        chk("rd_ack_t0", 32'(st[0][2]), 1);
        req0 = 1'b0;
        idle(6);

        // Write then read back at 8'hff
        req1 = 1'b1; rd1 = 1'b0; addr1 = 8'hff; wdata1 = 8'haa;
        wait_for(1, 3, 8, c);
        chk("wr_we_lat", c, 2);
        chk("wr_bus", 32'(busv[1]), 'haa);
        wait_for(1, 1, 8, c);
        chk("wr_ack_lat", c, 1);
        req1 = 1'b0;
        idle(6);
        req1 = 1'b1; rd1 = 1'b1;
        wait_for(1, 1, 8, c);
        chk("wr_readback", 32'(rdv[1]), 'haa);
        req1 = 1'b0;
        idle(6);

        // Both requesters held high on the TURN_CYCLES=1 instance
        req0 = 1'b1; rd0 = 1'b1; addr0 = 8'h03;
        req1 = 1'b1; rd1 = 1'b1; addr1 = 8'h04;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        eids[0] = 0; eids[1] = 1; eids[2] = 0; eids[3] = 1;
`else
        eids[0] = 0; eids[1] = 0; eids[2] = 0; eids[3] = 0;
`endif
        cnt_acks = 0;
        for (int t = 1; t <= 60 && cnt_acks < 4; t++) begin
            @(negedge CLK);
            if (st[1][2] || st[1][1]) begin
                ids[cnt_acks] = int'(st[1][1]);
                cyc[cnt_acks] = t;
                rds[cnt_acks] = rdv[1];
                cnt_acks++;
            end
        end
        chk("both_count", cnt_acks, 4);
        chk("both_first", cyc[0], 3);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("both_id%0d", j), ids[j], eids[j]);
            chk($sformatf("both_rdata%0d", j), 32'(rds[j]), 32'(8'h13 + 8'(eids[j])));
        end
        for (int j = 1; j < 4; j++) chk($sformatf("both_gap%0d", j), cyc[j] - cyc[j-1], 5);
        req0 = 1'b0; req1 = 1'b0;
        idle(8);

        // Back-to-back reads on the TURN_CYCLES=0 instance
        req0 = 1'b1; rd0 = 1'b1; addr0 = 8'h00;
        wait_for(0, 2, 8, c);
        chk("b2b_lat", c, 3);
        chk("b2b_rd0", 32'(rdv[0]), 'h10);
        addr0 = 8'h01;
        wait_for(0, 2, 8, c);
        chk("b2b_gap", c, 4);
        chk("b2b_rd1", 32'(rdv[0]), 'h11);
        req0 = 1'b0;
        idle(8);

        // Reset during the DATA cycle of a write
        req1 = 1'b1; rd1 = 1'b0; addr1 = 8'h05; wdata1 = 8'h5a;
        wait_for(1, 3, 8, c);
        chk("rstmid_we_lat", c, 2);
        RST = 1'b0;
        @(negedge CLK);
        chk("rstmid_ctl", 32'(st[1]), 0);
        chk("rstmid_busz", 32'(bz[1]), 1);
        chk("rstmid_rdata", 32'(rdv[1]), 0);
        @(negedge CLK);
        RST = 1'b1;
        wait_for(1, 1, 8, c);
        chk("rstmid_serve", c, 3);
        req1 = 1'b0;
        idle(6);
        req0 = 1'b1; rd0 = 1'b1; addr0 = 8'h05;
        wait_for(1, 2, 8, c);
        chk("rstmid_readback", 32'(rdv[1]), 'h5a);
        req0 = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 1, meaning bus-idle cycles inserted after each transfer (legal 0..3).
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports req0/req1  input  1 each  transfer request; requester 0 is instruction fetch, requester 1 is data access.
REQ-005 SHALL have ports rd0/rd1  input  1 each  1 = read, 0 = write.
REQ-006 SHALL have ports addr0/addr1  input  8 each  target address.
REQ-007 SHALL have ports wdata0/wdata1  input  8 each  write data.
REQ-008 SHALL have ports ack0/ack1  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have port rdata  output  8  read data, valid in the ack cycle.
REQ-010 SHALL have port uniBus  inout  8  multiplexed address/data bus to Memory.
REQ-011 SHALL have ports ale/mem_rd/mem_we  output  1 each  address-latch, read-strobe and write-strobe to Memory.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, ADDR, DATA, ACK, TURN.
REQ-014 In IDLE with any req high at an edge: SHALL latch winner's id, rd, addr and wdata, then go to ADDR.
REQ-015 In IDLE with no req: SHALL stay in IDLE with uniBus at high-Z.
REQ-016 ADDR (1 cycle): SHALL drive latched addr on uniBus with ale=1, then go to DATA.
REQ-017 DATA write (1 cycle): SHALL drive latched wdata on uniBus with mem_we=1.
REQ-018 DATA read (1 cycle): SHALL float uniBus, assert mem_rd=1 and capture uniBus into rdata at the closing edge.
REQ-019 ACK (1 cycle): SHALL pulse the winner's ack; uniBus high-Z; rdata holds captured value, or its previous value after a write.
REQ-020 After ACK: SHALL go to TURN for TURN_CYCLES cycles, then IDLE; with TURN_CYCLES=0 it SHALL go directly to IDLE.
REQ-021 Latency: req sampled at edge k; ale in cycle k+1; ack in cycle k+3; earliest next ale at k+5+TURN_CYCLES.
REQ-022 Requester SHALL hold req, rd, addr and wdata stable until its ack; the arbiter SHALL use only the values latched in IDLE.
REQ-023 req still high after ack SHALL be treated as a new request at the next IDLE evaluation.
REQ-024 The arbiter SHALL never assert ack0 and ack1 in the same cycle.
REQ-025 At most one of ale, mem_rd, mem_we SHALL be high in any cycle.
REQ-026 The arbiter SHALL drive uniBus only in ADDR and in write-DATA.
REQ-027 A req deasserted before ack (protocol violation) SHALL NOT abort the transfer; it completes and acks anyway.

Reset
REQ-028 While RST=0 at an edge: state SHALL go to IDLE.
REQ-029 While RST=0 at an edge: ack0, ack1, ale, mem_rd, mem_we and busy SHALL be 0, rdata 8'h00 and uniBus high-Z.
REQ-030 While RST=0 at an edge: the round-robin pointer (when compiled in) SHALL favor requester 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no ack; the first arbitration SHALL occur at the first edge with RST=1.

Configuration
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous req0 and req1, the grant SHALL go to the requester not served last, and the pointer SHALL update at each ACK.
REQ-033 Macro MEM_ARB_ROUND_ROBIN_EN undefined: requester 0 SHALL always win simultaneous requests (fixed priority) and no pointer state SHALL exist.

Verification
REQ-034 Scenario: mem[2]=8'h12, req0 read addr 8'h02 -> ale with uniBus=8'h02 in cycle k+1, ack0 in cycle k+3 with rdata=8'h12.
REQ-035 Scenario: req1 write addr 8'hff data 8'haa, then req1 read 8'hff -> mem_we cycle shows uniBus=8'haa; the read returns 8'haa.
REQ-036 Scenario: req0 and req1 held high continuously, TURN_CYCLES=1 -> round-robin: acks alternate 0,1,0,1 spaced 5 cycles apart; fixed priority: only ack0 pulses.
REQ-037 Scenario: TURN_CYCLES=0, back-to-back req0 reads of 8'h00 then 8'h01 -> ack0 pulses 4 cycles apart with rdata 8'h10 then 8'h11.
REQ-038 Scenario: RST=0 asserted during DATA of a write -> no ack; next edge shows all strobes 0 and uniBus=Z; after RST=1 the pending req is served.
REQ-039 Scenario: every cycle of all scenarios -> checker confirms no two strobes high, no dual ack, and uniBus never driven in IDLE, ACK or TURN.
